// File: rtl/maint_refresh_sched_if.sv
// maint_refresh_sched_if: command-path bus between the refresh scheduler and its neighbours.
// Signals: maint_req/maint_gnt arbiter handshake, maint_bank/maint_bank_state tracker query,
// instr/instr_valid/instr_ready maintenance instruction stream to the command sender.
// master = scheduler side, slave = arbiter/tracker/sender side.
interface maint_refresh_sched_if #(
    parameter int ROW_WIDTH  = 16,
    parameter int BANK_WIDTH = 3
);
    logic                  maint_req;
    logic                  maint_gnt;
    logic [BANK_WIDTH-1:0] maint_bank;
    logic [ROW_WIDTH-1:0]  maint_bank_state;
    logic [31:0]           instr;
    logic                  instr_valid;
    logic                  instr_ready;
    modport master (
        output maint_req, maint_bank, instr, instr_valid,
        input  maint_gnt, maint_bank_state, instr_ready
    );
    modport slave (
        input  maint_req, maint_bank, instr, instr_valid,
        output maint_gnt, maint_bank_state, instr_ready
    );
endinterface

// File: rtl/maint_refresh_sched.sv
// maint_refresh_sched: periodic DDR refresh scheduler (precharge open banks, REF, optional row restore).
// Ports: clk, rst (sync, active-high); ref_en enables the TREFI interval counter; ref_trig adds a credit;
// bus (master) carries arbiter request/grant, tracker query and the maintenance instruction stream;
// pend_cnt outstanding credits, urgent when saturated at MAX_PEND, busy when not idle.
// Build option: define REFRESH_ROW_RESTORE_EN to re-activate previously open rows after REF.
// Command layout: bit31=1, CS at [RAS+1 +: CS_WIDTH] (always 0), RAS/CAS/WE just above the bank field,
// bank at [ROW_WIDTH +: BANK_WIDTH], row at [ROW_WIDTH-1:0]. WAIT is 32'h4000_0000 | cycles.
module maint_refresh_sched #(
    parameter int ROW_WIDTH  = 16,
    parameter int BANK_WIDTH = 3,
    parameter int CS_WIDTH   = 1,
    parameter int TREFI      = 7800,
    parameter int TRP        = 4,
    parameter int TRFC       = 44,
    parameter int TRCD       = 4,
    parameter int MAX_PEND   = 8
) (
    input  logic                 clk,
    input  logic                 rst,
    input  logic                 ref_en,
    input  logic                 ref_trig,
    maint_refresh_sched_if.master bus,
    output logic [3:0]           pend_cnt,
    output logic                 urgent,
    output logic                 busy
);
    localparam int CW    = $clog2(TREFI);
    localparam int WE_B  = ROW_WIDTH + BANK_WIDTH;
    localparam int CAS_B = WE_B + 1;
    localparam int RAS_B = WE_B + 2;
    localparam int CS_B  = WE_B + 3;
    localparam logic [31:0] CS_MASK  = ((32'd1 << CS_WIDTH) - 32'd1) << CS_B;
    localparam logic [31:0] CMD_BASE = 32'h8000_0000 & ~CS_MASK & ~(32'd1 << RAS_B);

    typedef enum logic [3:0] {IDLE, REQ, SCAN, WRP, REF, WRFC, RESTORE, WRCD, DONE} state_t;

    state_t                state, nxt;
    logic [BANK_WIDTH-1:0] bank, bank_n;
    logic                  pre_any, pre_n;
    logic [CW-1:0]         cnt;
    logic                  tick, credit, dec, open;
    logic [31:0]           cmd_pre, cmd_ref;

    assign open     = bus.maint_bank_state[ROW_WIDTH-1];
    assign cmd_pre  = CMD_BASE | (32'd1 << CAS_B) | (32'(bank) << ROW_WIDTH);
    assign cmd_ref  = CMD_BASE | (32'd1 << WE_B);
    assign tick     = ref_en && cnt == CW'(TREFI - 1);
    assign credit   = tick || ref_trig;
    assign urgent   = pend_cnt == 4'(MAX_PEND);
    assign busy     = state != IDLE;
    assign bus.maint_bank = bank;

`ifdef REFRESH_ROW_RESTORE_EN
    logic        act_any, act_n;
    logic [31:0] cmd_act;
    assign cmd_act = CMD_BASE | (32'd1 << CAS_B) | (32'd1 << WE_B) | (32'(bank) << ROW_WIDTH)
                   | 32'(bus.maint_bank_state[ROW_WIDTH-2:0]);
    always_ff @(posedge clk) act_any <= rst ? 1'b0 : act_n;
`else
    // row bits only matter when rows are restored
    logic unused_row;
    assign unused_row = ^bus.maint_bank_state[ROW_WIDTH-2:0];
`endif

    always_ff @(posedge clk) begin
        if (rst) begin
            state    <= IDLE;
            bank     <= '0;
            pre_any  <= 1'b0;
            cnt      <= '0;
            pend_cnt <= '0;
        end else begin
            state    <= nxt;
            bank     <= bank_n;
            pre_any  <= pre_n;
            cnt      <= tick ? '0 : ref_en ? cnt + 1'b1 : cnt;
            pend_cnt <= (credit && !dec) ? (urgent ? pend_cnt : pend_cnt + 4'd1)
                      : (dec && !credit) ? pend_cnt - 4'd1 : pend_cnt;
        end
    end

    always_comb begin
        nxt             = state;
        bank_n          = bank;
        pre_n           = pre_any;
`ifdef REFRESH_ROW_RESTORE_EN
        act_n           = act_any;
`endif
        dec             = 1'b0;
        bus.maint_req   = state != IDLE && state != DONE;
        bus.instr_valid = 1'b0;
        bus.instr       = '0;
        case (state)
            IDLE: nxt = pend_cnt != 0 ? REQ : IDLE;
            REQ: begin
                if (bus.maint_gnt) begin
                    nxt    = SCAN;
                    bank_n = '0;
                    pre_n  = 1'b0;
                end
            end
            // closed banks step through in one cycle, open ones wait for their PRE to be taken
            SCAN: begin
                bus.instr_valid = open;
                bus.instr       = open ? cmd_pre : '0;
                if (!open || bus.instr_ready) begin
                    bank_n = bank + 1'b1;
                    pre_n  = pre_any | open;
                    nxt    = &bank ? WRP : SCAN;
                end
            end
            WRP: begin
                bus.instr_valid = pre_any;
                bus.instr       = pre_any ? 32'h4000_0000 | 32'(TRP) : '0;
                nxt             = (!pre_any || bus.instr_ready) ? REF : WRP;
            end
            REF: begin
                bus.instr_valid = 1'b1;
                bus.instr       = cmd_ref;
                dec             = bus.instr_ready;
                nxt             = bus.instr_ready ? WRFC : REF;
            end
            WRFC: begin
                bus.instr_valid = 1'b1;
                bus.instr       = 32'h4000_0000 | 32'(TRFC);
                if (bus.instr_ready) begin
`ifdef REFRESH_ROW_RESTORE_EN
                    nxt    = RESTORE;
                    bank_n = '0;
                    act_n  = 1'b0;
`else
                    nxt    = DONE;
`endif
                end
            end
`ifdef REFRESH_ROW_RESTORE_EN
            // tracker is frozen during maintenance, so it still shows the rows seen in SCAN
            RESTORE: begin
                bus.instr_valid = open;
                bus.instr       = open ? cmd_act : '0;
                if (!open || bus.instr_ready) begin
                    bank_n = bank + 1'b1;
                    act_n  = act_any | open;
                    nxt    = &bank ? WRCD : RESTORE;
                end
            end
            WRCD: begin
                bus.instr_valid = act_any;
                bus.instr       = act_any ? 32'h4000_0000 | 32'(TRCD) : '0;
                nxt             = (!act_any || bus.instr_ready) ? DONE : WRCD;
            end
`endif
            DONE:    nxt = IDLE;
            default: nxt = IDLE;
        endcase
    end
endmodule

// File: doc/maint_refresh_sched.md
Name: maint_refresh_sched

Overview:
- Maintenance scheduler that periodically takes the DDR command stream from the application path and issues a refresh sequence.
- Sequence: precharge every open bank, issue REF, optionally re-open the rows that were open before.
- Per-bank open/row state comes from the bank-state tracker, read combinationally via maint_bank / maint_bank_state.
- Output instructions go to the command sender as maintenance instructions (is_mnt path).

Parameters:
ROW_WIDTH, 16, tracker state width; bit [ROW_WIDTH-1] is the open flag, bits [ROW_WIDTH-2:0] are the row.
BANK_WIDTH, 3, bank index width; NUM_BANKS = 1<<BANK_WIDTH.
CS_WIDTH, 1, chip-select field width.
TREFI, 7800, cycles between refresh credits.
TRP, 4, wait cycles after the last PRE.
TRFC, 44, wait cycles after REF.
TRCD, 4, wait cycles after the last ACT.
MAX_PEND, 8, refresh credit saturation value.

Ports:
clk  in  1  clock
rst  in  1  synchronous, active-high reset
ref_en  in  1  enables periodic credit accumulation
ref_trig  in  1  one-cycle pulse; adds one credit
maint_req  out  1  request ownership of the command path
maint_gnt  in  1  grant from the app/maint arbiter
maint_bank  out  BANK_WIDTH  bank queried in the tracker
maint_bank_state  in  ROW_WIDTH  tracker reply for maint_bank, same cycle
instr  out  32  maintenance instruction
instr_valid  out  1  instr valid (is_mnt)
instr_ready  in  1  sender accepts instr
pend_cnt  out  4  outstanding refresh credits
urgent  out  1  pend_cnt == MAX_PEND
busy  out  1  FSM not in IDLE

Behaviour:
- Reset values: maint_req, instr_valid, busy and urgent = 0; instr = 0; maint_bank = 0; pend_cnt = 0; FSM = IDLE; interval counter = 0.
- Reset mid-sequence aborts immediately. No further instructions are issued; the bank tracker is not touched.
- Interval counter: counts while ref_en=1. When it reaches TREFI-1 it wraps to 0 and generates a credit. ref_en=0 holds the counter value.
- Credits:
  - credit (tick or ref_trig) increments pend_cnt, saturating at MAX_PEND;
  - issued REF decrements pend_cnt;
  - tick and ref_trig in the same cycle count as one credit;
  - credit and REF accepted in the same cycle leave pend_cnt unchanged.
- Handshake: instr and instr_valid are held stable until instr_ready=1. A transfer occurs when valid && ready; the next instruction may be presented on the following cycle.
- Instruction encoding:
  - DDR cmd: bit31=1, CS field=0, bank at [ROW_WIDTH +: BANK_WIDTH], row at [ROW_WIDTH-1:0], RAS/CAS/WE at the codebase offsets.
  - PRE: RAS=0, CAS=1, WE=0, row field = 0.
  - ACT: RAS=0, CAS=1, WE=1.
  - REF: RAS=0, CAS=0, WE=1, bank/row = 0.
  - WAIT: 32'h4000_0000 | n, with n = cycle count.
- FSM transitions:
  - IDLE: if pend_cnt>0 -> REQ.
  - REQ: maint_req=1; stay until maint_gnt=1 -> SCAN with maint_bank=0. maint_req stays high until DONE. maint_gnt is sampled only in REQ.
  - SCAN: one bank per step. If maint_bank_state[MSB]=1, present PRE for that bank and advance after acceptance; closed banks advance in one cycle with no output. After bank NUM_BANKS-1 -> WRP.
  - WRP: if at least one PRE was issued, present WAIT TRP; otherwise skip. -> REF.
  - REF: present REF. On acceptance decrement pend_cnt -> WRFC.
  - WRFC: present WAIT TRFC. -> RESTORE with maint_bank=0, or DONE if the feature is absent.
  - RESTORE: per bank whose tracker state shows open, present ACT with row = state[ROW_WIDTH-2:0] zero-extended. After the last bank -> WRCD.
  - WRCD: present WAIT TRCD if any ACT was issued. -> DONE.
  - DONE: maint_req=0 for one cycle -> IDLE. If credits remain, a new REQ starts next cycle.
- Tracker state reads: the tracker updates only on app instructions, so state read in RESTORE equals state read in SCAN.
- All banks closed: no PRE, no ACT, no TRP/TRCD waits; the sequence is REF + WAIT TRFC only.

Optional Feature:
REFRESH_ROW_RESTORE_EN:
- Defined: RESTORE and WRCD states are present; open rows are reactivated after REF.
- Undefined: after WRFC go directly to DONE; banks are left precharged, and the application must re-ACT.

Test Plan:
- TREFI=100, ref_en=1, maint_gnt tied 1, all banks closed, ready=1 -> at cycle 100 pend_cnt=1, then instrs REF, WAIT 44; pend_cnt returns to 0.
- Banks 2 (row 0x0123) and 5 (row 0x7FFF) open -> PRE b2, PRE b5, WAIT 4, REF, WAIT 44, ACT b2 r0x0123, ACT b5 r0x7FFF, WAIT 4. With the macro undefined, stop after WAIT 44.
- maint_gnt held 0 for 20 cycles -> maint_req=1 throughout, instr_valid=0; first PRE appears 1 cycle after gnt rises.
- instr_ready toggling 1-of-3 cycles -> instr/instr_valid stable while stalled; each instruction emitted exactly once.
- ref_en=1, gnt=0 for 9*TREFI -> pend_cnt saturates at 8, urgent=1. ref_trig coincident with a REF acceptance leaves pend_cnt unchanged.
- rst asserted during WRFC -> next cycle maint_req=0, instr_valid=0, pend_cnt=0, busy=0.
